dmem_arbiter: RTL

- Shares the single-port 64-bit data memory between two requesters: the CPU pipeline MEM stage and the external host/loader port.
- Sits between those requesters and the data memory macro.
- Default policy is CPU priority, with a bounded-wait anti-starvation counter for the host and a host lock mode for burst loads.
- Produces a stall to gate the CPU pipeline enable whenever a CPU access is denied.

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_arbiter_wait_counter.sv | 24 ++
 rtl/dmem_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned MAX_WAIT_DEF = 4;
  localparam int unsigned WAIT_CNT_W   = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_arbiter_wait_counter.sv
// Saturating host-starvation counter; at_max forces a host grant.
module arb_wait_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX = MAX_WAIT_DEF
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  logic [WAIT_CNT_W-1:0] r_cnt;

  assign o_at_max = (r_cnt == WAIT_CNT_W'(MAX));

  always_ff @(posedge i_clk) begin
    if (i_srst)                   r_cnt <= '0;
    else if (i_clr)               r_cnt <= '0;
    else if (i_inc && !o_at_max)  r_cnt <= r_cnt + WAIT_CNT_W'(1);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU priority, bounded host wait, host lock.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_gnt,
  output logic              o_cpu_stall,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_ext_req,
  input  logic              i_ext_we,
  input  logic              i_ext_lock,
  input  logic [ADDR_W-1:0] i_ext_addr,
  input  logic [DATA_W-1:0] i_ext_wdata,
  output logic              o_ext_gnt,
  output logic              o_ext_rvalid,
  output logic [DATA_W-1:0] o_ext_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wen,
  output logic              o_mem_ren,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  state_e r_state;
  state_e w_state_nxt;
  owner_e r_rd_owner;
  logic   w_cpu_gnt;
  logic   w_ext_gnt;
  logic   w_at_max;
  logic   w_cpu_rvalid;
  logic   w_ext_rvalid;

  arb_wait_counter #(.MAX(MAX_WAIT)) u_wait_cnt (
    .i_clk    (i_clk),
    .i_srst   (i_srst),
    .i_inc    (i_ext_req & ~w_ext_gnt),
    .i_clr    (w_ext_gnt | ~i_ext_req),
    .o_at_max (w_at_max)
  );

  always_ff @(posedge i_clk) begin
    if (i_srst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A lock cycle with ext_lock already dropped is arbitrated as IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cpu_gnt   = 1'b0;
    w_ext_gnt   = 1'b0;
    if (!i_srst) begin
      if (r_state == ST_LOCK && i_ext_lock) begin
        w_ext_gnt = i_ext_req;
      end else begin
        w_state_nxt = ST_IDLE;
        if (i_ext_req && i_ext_lock) begin
          w_ext_gnt   = 1'b1;
          w_state_nxt = ST_LOCK;
        end else if (i_ext_req && w_at_max) begin
          w_ext_gnt = 1'b1;
        end else if (i_cpu_req) begin
          w_cpu_gnt = 1'b1;
        end else if (i_ext_req) begin
          w_ext_gnt = 1'b1;
        end
      end
    end
  end

  assign o_cpu_gnt   = w_cpu_gnt;
  assign o_ext_gnt   = w_ext_gnt;
  assign o_cpu_stall = i_cpu_req & ~w_cpu_gnt;

  assign o_mem_wen   = (w_cpu_gnt & i_cpu_we) | (w_ext_gnt & i_ext_we);
  assign o_mem_ren   = (w_cpu_gnt & ~i_cpu_we) | (w_ext_gnt & ~i_ext_we);
  assign o_mem_addr  = w_cpu_gnt ? i_cpu_addr  : (w_ext_gnt ? i_ext_addr  : '0);
  assign o_mem_wdata = w_cpu_gnt ? i_cpu_wdata : (w_ext_gnt ? i_ext_wdata : '0);

  always_ff @(posedge i_clk) begin
    if (i_srst)                     r_rd_owner <= OWN_NONE;
    else if (w_cpu_gnt & ~i_cpu_we) r_rd_owner <= OWN_CPU;
    else if (w_ext_gnt & ~i_ext_we) r_rd_owner <= OWN_EXT;
    else                            r_rd_owner <= OWN_NONE;
  end

  // Return data is suppressed during reset so a pending read is dropped.
  assign w_cpu_rvalid = (r_rd_owner == OWN_CPU) & ~i_srst;
  assign w_ext_rvalid = (r_rd_owner == OWN_EXT) & ~i_srst;
  assign o_cpu_rvalid = w_cpu_rvalid;
  assign o_ext_rvalid = w_ext_rvalid;
  assign o_cpu_rdata  = w_cpu_rvalid ? i_mem_rdata : '0;
  assign o_ext_rdata  = w_ext_rvalid ? i_mem_rdata : '0;

endmodule
